// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// instruction encodings, cause codes, pipeline hold levels, the sequencer
// state encoding and the mstatus update rules applied on trap entry / mret.
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

  // CSR write-port addresses
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;

  // Instruction encodings recognised in decode
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // mcause values
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

  // Pipeline hold protocol with the control block
  localparam logic       HOLD_ENABLE = 1'b1;
  localparam logic [2:0] HOLD_NONE   = 3'd0;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEPC     = 3'd1,
    S_MCAUSE   = 3'd2,
    S_MSTATUS  = 3'd3,
    S_ASSERT   = 3'd4,
    S_MRET     = 3'd5,
    S_ASSERT_R = 3'd6
  } state_t;

  // Trap entry: MPIE <- MIE, MIE <- 0.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r               = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // mret: MIE <- MPIE, MPIE <- 1.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r               = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap sequencer. Detects ecall/ebreak, mret and external
// interrupts in decode, holds the pipeline, writes mepc/mcause/mstatus over
// successive cycles and then redirects fetch to mtvec (or to mepc for mret).
//
// Ports
//   clk            core clock
//   rst            synchronous active-high reset
//   inst_i         instruction in decode
//   inst_addr_i    address of inst_i
//   hold_flag_i    current pipeline hold level (HOLD_NONE = 0)
//   int_flag_i     external interrupt lines, level sensitive
//   csr_mtvec_i    live mtvec
//   csr_mepc_i     live mepc
//   csr_mstatus_i  live mstatus (bit3 MIE, bit7 MPIE)
//   hold_flag_o    hold request to control block
//   we_o           CSR write enable
//   waddr_o        CSR write address
//   data_o         CSR write data
//   int_assert_o   one-cycle redirect strobe
//   int_addr_o     redirect target
// -----------------------------------------------------------------------------
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [2:0]  hold_flag_i,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_epc;
  logic [31:0] r_cause;

  logic        w_can_detect;
  logic        w_is_sync;
  logic        w_is_mret;
  logic        w_is_async;
  logic        w_trap_detect;
  logic        w_mret_detect;
  logic [31:0] w_trap_cause;

  // Detection is only allowed from IDLE with no other stall or jump in
  // flight; everything it looks at is level, so a deferred request is simply
  // seen again on a later cycle.
  assign w_can_detect = (r_state == S_IDLE) && (hold_flag_i == HOLD_NONE) && !rst;
  assign w_is_sync    = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
  assign w_is_mret    = (inst_i == INST_MRET);
  assign w_is_async   = (int_flag_i != 8'd0) && csr_mstatus_i[MSTATUS_MIE];

  // Priority sync > mret > async.
  assign w_trap_detect = w_can_detect && (w_is_sync || (!w_is_mret && w_is_async));
  assign w_mret_detect = w_can_detect && !w_is_sync && w_is_mret;

  assign w_trap_cause = (inst_i == INST_ECALL)  ? CAUSE_ECALL  :
                        (inst_i == INST_EBREAK) ? CAUSE_EBREAK :
                                                  CAUSE_EXT_INT;

  // NOTE: state and latches use non-blocking assignments so every register
  // updates from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_epc   <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_trap_detect) begin
        r_epc   <= inst_addr_i;
        r_cause <= w_trap_cause;
      end
    end
  end

  // NOTE: next state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_trap_detect)      w_next_state = S_MEPC;
        else if (w_mret_detect) w_next_state = S_MRET;
      end
      S_MEPC:     w_next_state = S_MCAUSE;
      S_MCAUSE:   w_next_state = S_MSTATUS;
      S_MSTATUS:  w_next_state = S_ASSERT;
      S_ASSERT:   w_next_state = S_IDLE;
      S_MRET:     w_next_state = S_ASSERT_R;
      S_ASSERT_R: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Combinational hold so the control block stalls in the detect cycle itself.
  assign hold_flag_o = ((r_state != S_IDLE) || w_trap_detect || w_mret_detect)
                       ? HOLD_ENABLE : ~HOLD_ENABLE;

  // CSR write port and redirect, decoded from the state register.
  always_comb begin
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (r_state)
      S_MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = r_epc;
      end
      S_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = r_cause;
      end
      S_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_on_trap(csr_mstatus_i);
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i;
      end
      S_MRET: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_on_mret(csr_mstatus_i);
      end
      S_ASSERT_R: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule
